// File: rtl/data_memory_sized.sv
// Byte-lane data memory for the MIPS datapath with a valid/ready request and a one-cycle response pulse.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses report resp_err and do not write.
module data_memory_sized #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        resp_valid,
    output logic [31:0] read_data,
    output logic        resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    logic        cap_write;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [31:0] cap_addr;
    logic        cap_err;

    logic        accept;
    logic        in_err;
    logic        eff_write;
    logic [1:0]  eff_size;
    logic        eff_unsigned;
    logic [31:0] eff_addr;
    logic        eff_err;
    logic [31:0] resp_data;
    logic [3:0]  wr_mask;
    logic [31:0] wr_lanes;

    function automatic logic access_error(input logic [31:0] a, input logic [1:0] size);
        logic err;
        // A word index at or past DEPTH_WORDS covers every nonzero high address bit.
        err = ((a >> 2) >= 32'(DEPTH_WORDS)) || (size == 2'b11);
`ifdef MISALIGN_TRAP_EN
        if ((size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00))
            err = 1'b1;
`endif
        return err;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] replicate_lanes(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                                 input logic [1:0] lo, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] shifted;
        shifted = word >> {lo, 3'b000};
        b = shifted[7:0];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
            2'b10:   return word;
            default: return 32'd0;
        endcase
    endfunction

    assign accept   = req_valid & req_ready;
    assign in_err   = access_error(addr, req_size);
    assign wr_mask  = lane_mask(req_size, addr[1:0]);
    assign wr_lanes = replicate_lanes(req_size, write_data);

    // With LATENCY=1 the response is formed on the accept edge itself, so use the live request there.
    always_comb begin
        eff_write    = cap_write;
        eff_size     = cap_size;
        eff_unsigned = cap_unsigned;
        eff_addr     = cap_addr;
        eff_err      = cap_err;
        if (state == IDLE) begin
            eff_write    = req_write;
            eff_size     = req_size;
            eff_unsigned = req_unsigned;
            eff_addr     = addr;
            eff_err      = in_err;
        end
    end

    always_comb begin
        resp_data = 32'd0;
        if (!eff_write && !eff_err)
            resp_data = load_extract(eff_size, eff_unsigned, eff_addr[1:0], mem[eff_addr[AW+1:2]]);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_write    <= req_write;
            cap_size     <= req_size;
            cap_unsigned <= req_unsigned;
            cap_addr     <= addr;
            cap_err      <= in_err;
        end
    end

    // Stores commit at the accept edge; an erroring store leaves the array untouched.
    always_ff @(posedge clk) begin
        if (!rst && accept && req_write && !in_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i])
                    mem[addr[AW+1:2]][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            read_data  <= 32'd0;
            resp_err   <= 1'b0;
            cnt        <= 4'd0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (LATENCY > 1) begin
                            state <= BUSY;
                            cnt   <= 4'(LATENCY - 2);
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            read_data  <= resp_data;
                            resp_err   <= eff_err;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        read_data  <= resp_data;
                        resp_err   <= eff_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: one LATENCY=1 instance and one LATENCY=4 instance
// sharing request fields, each with its own req_valid.
module tb_data_memory_sized;

    logic        clk;
    logic        rst;
    logic        v1, v4;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        rdy1, rdy4, rv1, rv4, er1, er4;
    logic [31:0] rd1, rd4;

    int total;
    int passed;
    int fails;

    data_memory_sized #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .addr(addr), .write_data(write_data),
        .resp_valid(rv1), .read_data(rd1), .resp_err(er1));

    data_memory_sized #(.DEPTH_WORDS(256), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_ready(rdy4), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .addr(addr), .write_data(write_data),
        .resp_valid(rv4), .read_data(rd4), .resp_err(er4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic txn(input bit d4, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input string tag,
                       output logic [31:0] rd, output logic er);
        int lat;
        int n;
        lat = d4 ? 4 : 1;
        req_write = w; req_size = sz; req_unsigned = u; addr = a; write_data = wd;
        if (d4) v4 = 1'b1; else v1 = 1'b1;
        check({tag, "/ready"}, 32'(d4 ? rdy4 : rdy1), 32'd1);
        @(posedge clk); #1;
        v1 = 1'b0; v4 = 1'b0;
        n = 1;
        while (!(d4 ? rv4 : rv1) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "/latency"}, 32'(n), 32'(lat));
        rd = d4 ? rd4 : rd1;
        er = d4 ? er4 : er1;
        @(posedge clk); #1;
        check({tag, "/pulse_end"}, 32'(d4 ? rv4 : rv1), 32'd0);
    endtask

    task automatic st(input bit d4, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic exp_err, input string tag);
        logic [31:0] rd;
        logic er;
        txn(d4, 1'b1, sz, 1'b0, a, wd, tag, rd, er);
        check({tag, "/err"}, 32'(er), 32'(exp_err));
        check({tag, "/rdata"}, rd, 32'd0);
    endtask

    task automatic ld(input bit d4, input logic [1:0] sz, input logic u, input logic [31:0] a,
                      input logic [31:0] exp, input logic exp_err, input string tag);
        logic [31:0] rd;
        logic er;
        txn(d4, 1'b0, sz, u, a, 32'd0, tag, rd, er);
        check({tag, "/err"}, 32'(er), 32'(exp_err));
        check({tag, "/rdata"}, rd, exp);
    endtask

    initial begin
        int seen;
        total = 0; passed = 0; fails = 0;
        rst = 1'b1; v1 = 1'b0; v4 = 1'b0;
        req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; addr = '0; write_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/ready", 32'(rdy1), 32'd1);
        check("reset/resp_valid", 32'(rv1), 32'd0);
        check("reset/read_data", rd1, 32'd0);
        check("reset/resp_err", 32'(er1), 32'd0);
        check("reset/ready4", 32'(rdy4), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word store and load
        st(0, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, "sw10");
        ld(0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, "lw10");

        // Byte store with sign/zero-extended loads
        st(0, 2'b10, 32'h20, 32'h0, 1'b0, "sw20_clear");
        st(0, 2'b00, 32'h21, 32'h12345680, 1'b0, "sb21");
        ld(0, 2'b00, 1'b0, 32'h21, 32'hFFFFFF80, 1'b0, "lb21");
        ld(0, 2'b00, 1'b1, 32'h21, 32'h00000080, 1'b0, "lbu21");
        ld(0, 2'b10, 1'b0, 32'h20, 32'h00008000, 1'b0, "lw20");

        // Half stores into both halves
        st(0, 2'b10, 32'h30, 32'h0, 1'b0, "sw30_clear");
        st(0, 2'b01, 32'h32, 32'hABCD1234, 1'b0, "sh32");
        ld(0, 2'b01, 1'b0, 32'h32, 32'h00001234, 1'b0, "lh32");
        ld(0, 2'b10, 1'b0, 32'h30, 32'h12340000, 1'b0, "lw30");
        st(0, 2'b01, 32'h30, 32'h00008001, 1'b0, "sh30");
        ld(0, 2'b01, 1'b0, 32'h30, 32'hFFFF8001, 1'b0, "lh30");
        ld(0, 2'b01, 1'b1, 32'h30, 32'h00008001, 1'b0, "lhu30");
        ld(0, 2'b10, 1'b0, 32'h30, 32'h12348001, 1'b0, "lw30b");

        // Out of range and reserved size
        st(0, 2'b10, 32'h0, 32'hCAFEF00D, 1'b0, "sw0");
        st(0, 2'b10, 32'h400, 32'h11111111, 1'b1, "sw400_oob");
        ld(0, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, "lw0_after_oob");
        ld(0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, "ld_reserved");
        ld(0, 2'b10, 1'b0, 32'h3FC, 32'h0, 1'b0, "lw3fc_last");

        // Misaligned word store
        st(0, 2'b10, 32'h40, 32'h0, 1'b0, "sw40_clear");
`ifdef MISALIGN_TRAP_EN
        st(0, 2'b10, 32'h42, 32'hA5A5A5A5, 1'b1, "sw42_misalign");
        ld(0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, "lw40");
`else
        st(0, 2'b10, 32'h42, 32'hA5A5A5A5, 1'b0, "sw42_misalign");
        ld(0, 2'b10, 1'b0, 32'h40, 32'hA5A5A5A5, 1'b0, "lw40");
`endif

        // LATENCY=4 instance: timing, and inputs toggled while busy are ignored
        st(1, 2'b10, 32'h8, 32'h01020304, 1'b0, "l4_sw8");
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; addr = 32'h8; write_data = '0;
        v4 = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("l4_busy%0d/ready", c), 32'(rdy4), 32'd0);
            check($sformatf("l4_busy%0d/resp", c), 32'(rv4), 32'd0);
            req_write = 1'b1; req_size = 2'(c); req_unsigned = ~req_unsigned;
            addr = 32'h8 + 32'(c); write_data = 32'hFFFF0000 | 32'(c);
            @(posedge clk); #1;
        end
        v4 = 1'b0;
        check("l4_c4/ready", 32'(rdy4), 32'd0);
        check("l4_c4/resp", 32'(rv4), 32'd1);
        check("l4_c4/rdata", rd4, 32'h01020304);
        check("l4_c4/err", 32'(er4), 32'd0);
        @(posedge clk); #1;
        check("l4_c5/resp", 32'(rv4), 32'd0);
        check("l4_c5/ready", 32'(rdy4), 32'd1);
        ld(1, 2'b10, 1'b0, 32'h8, 32'h01020304, 1'b0, "l4_lw8_again");

        // Reset while busy: response dropped, store already committed
        req_write = 1'b1; req_size = 2'b10; addr = 32'hC; write_data = 32'h00000077;
        v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy/ready", 32'(rdy4), 32'd1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (rv4) seen++;
            @(posedge clk); #1;
        end
        check("rst_busy/no_resp", 32'(seen), 32'd0);
        ld(1, 2'b10, 1'b0, 32'hC, 32'h00000077, 1'b0, "rst_busy/lwC");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
